// File: rtl/fed_sfu_pkg.sv
// Shared definitions for the fed_sfu execute unit: op codes, FSM states and
// the key reset default.
package fed_sfu_pkg;

  localparam int unsigned OP_W        = 3;
  localparam int unsigned DEF_DATA_W  = 19;

  localparam logic [OP_W-1:0] OP_FFT = 3'b001;
  localparam logic [OP_W-1:0] OP_DEC = 3'b010;
  localparam logic [OP_W-1:0] OP_ENC = 3'b100;

  localparam logic [DEF_DATA_W-1:0] KEY_RST_DEF = 19'h003FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for the two ops that go through the multi-round cipher loop.
  function automatic logic is_cipher_op(input logic [OP_W-1:0] op);
    return (op == OP_ENC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/fed_sfu_butterfly.sv
// Combinational 2-point butterfly on signed SAMPLE_W samples.
// Optional saturation of both results with macro FED_SFU_SATURATE_EN;
// without it, sum and difference wrap modulo 2^SAMPLE_W.
module fed_sfu_butterfly #(
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic [SAMPLE_W-1:0] a_i,
  input  logic [SAMPLE_W-1:0] b_i,
  output logic [SAMPLE_W-1:0] sum_o,
  output logic [SAMPLE_W-1:0] diff_o
);

`ifdef FED_SFU_SATURATE_EN
  localparam int unsigned EXT_W = SAMPLE_W + 1;

  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] diff_ext;

  // Clamp a one-bit-wider signed result back into SAMPLE_W range.
  function automatic logic [SAMPLE_W-1:0] sat(input logic [EXT_W-1:0] v);
    if (v[EXT_W-1] != v[EXT_W-2]) begin
      return v[EXT_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                        : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    return v[SAMPLE_W-1:0];
  endfunction

  assign sum_ext  = {a_i[SAMPLE_W-1], a_i} + {b_i[SAMPLE_W-1], b_i};
  assign diff_ext = {a_i[SAMPLE_W-1], a_i} - {b_i[SAMPLE_W-1], b_i};
  assign sum_o    = sat(sum_ext);
  assign diff_o   = sat(diff_ext);
`else
  assign sum_o  = a_i + b_i;
  assign diff_o = a_i - b_i;
`endif

endmodule

// File: rtl/fed_sfu.sv
// fed_sfu: handshaked FFT-butterfly / keyed-cipher execute unit.
// ENC/DEC run ROUNDS rounds (one per cycle) with a key snapshot taken at
// accept; FFT and illegal ops complete one cycle after accept.
// Optional macro FED_SFU_SATURATE_EN makes the butterfly saturate.
module fed_sfu
  import fed_sfu_pkg::*;
#(
  parameter int unsigned     DATA_W   = 19,
  parameter int unsigned     SAMPLE_W = 8,
  parameter int unsigned     ROUNDS   = 2,
  parameter logic [DATA_W-1:0] KEY_RST = DATA_W'(KEY_RST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_op,
  input  logic              key_we,
  input  logic [DATA_W-1:0] key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int unsigned CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] ks_q, ks_d;
  logic              enc_q, enc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              oe_q, oe_d;

  logic [SAMPLE_W-1:0] bf_sum, bf_diff;
  logic [DATA_W-1:0]   fft_res;
  logic [DATA_W-1:0]   round_x;
  logic [DATA_W-1:0]   mix;

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

  function automatic logic [DATA_W-1:0] rotr1(input logic [DATA_W-1:0] v);
    return {v[0], v[DATA_W-1:1]};
  endfunction

  fed_sfu_butterfly #(
    .SAMPLE_W (SAMPLE_W)
  ) u_butterfly (
    .a_i    (in_data[2*SAMPLE_W-1:SAMPLE_W]),
    .b_i    (in_data[SAMPLE_W-1:0]),
    .sum_o  (bf_sum),
    .diff_o (bf_diff)
  );

  assign fft_res = DATA_W'({bf_sum, bf_diff});

  // One cipher round on the working value with the snapshot key.
  assign mix     = x_q ^ ks_q;
  assign round_x = enc_q ? rotl1(mix) : (rotr1(x_q) ^ ks_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_err   = oe_q;

  // Next-state, datapath and result logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    key_d   = key_q;
    ks_d    = ks_q;
    enc_d   = enc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    oe_d    = oe_q;

    if (key_we) begin
      key_d = key_in;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ks_d = key_q;
          if (is_cipher_op(in_op)) begin
            x_d     = in_data;
            enc_d   = (in_op == OP_ENC);
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            ov_d    = 1'b1;
            state_d = DONE;
            if (in_op == OP_FFT) begin
              od_d = fft_res;
              oe_d = 1'b0;
            end else begin
              od_d = '0;
              oe_d = 1'b1;
            end
          end
        end
      end
      RUN: begin
        x_d = round_x;
        if (cnt_q == LAST_RND) begin
          cnt_d   = '0;
          ov_d    = 1'b1;
          od_d    = round_x;
          oe_d    = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      key_q   <= KEY_RST;
      ks_q    <= '0;
      enc_q   <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      key_q   <= key_d;
      ks_q    <= ks_d;
      enc_q   <= enc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oe_q    <= oe_d;
    end
  end

endmodule

// File: tb/tb_fed_sfu.sv
// Self-checking bench for fed_sfu with default parameters.
module tb_fed_sfu;

  localparam int unsigned DW  = 19;
  localparam int unsigned SW  = 8;
  localparam int unsigned RND = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            lat;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_op;
  logic          key_we;
  logic [DW-1:0] key_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  int            n_tests = 0;
  int            n_fail  = 0;
  exp_t          sb[$];
  logic [DW-1:0] tb_key;

  fed_sfu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .key_we    (key_we),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] enc_m(input logic [DW-1:0] x, input logic [DW-1:0] k);
    logic [DW-1:0] t;
    for (int r = 0; r < RND; r++) begin
      t = x ^ k;
      x = {t[DW-2:0], t[DW-1]};
    end
    return x;
  endfunction

  function automatic int fit(input int v);
`ifdef FED_SFU_SATURATE_EN
    if (v > 127)  return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  function automatic logic [DW-1:0] fft_m(input logic [DW-1:0] din);
    int a, b, s, df;
    logic [7:0] s8, d8;
    a  = int'($signed(din[15:8]));
    b  = int'($signed(din[7:0]));
    s  = fit(a + b);
    df = fit(a - b);
    s8 = s[7:0];
    d8 = df[7:0];
    return {3'b000, s8, d8};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one op, wait for its result, compare against the scoreboard,
  // optionally hold backpressure, then take the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [DW-1:0] din,
                        input logic [DW-1:0] exp_d, input logic exp_e, input int exp_lat,
                        input int hold, input logic kwe, input logic [DW-1:0] kin);
    exp_t e;
    int   w;
    int   lat;
    e.d = exp_d; e.e = exp_e; e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = din; key_we = kwe; key_in = kin;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "/ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; key_we = 1'b0;
    if (kwe) tb_key = kin;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "/lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "/data"}, 32'(out_data), 32'(e.d));
    chk({tag, "/err"}, 32'(out_err), 32'(e.e));
    chk({tag, "/busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "/hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "/hold_d"}, 32'(out_data), 32'(e.d));
      chk({tag, "/hold_r"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/drop_v"}, 32'(out_valid), 32'd0);
    chk({tag, "/idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] r;
    logic [DW-1:0] c;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = 3'b000;
    key_we = 1'b0; key_in = '0; out_ready = 1'b0;
    tb_key = 19'h003FF;
    repeat (3) @(negedge clk);
    chk("rst/valid", 32'(out_valid), 32'd0);
    chk("rst/data", 32'(out_data), 32'd0);
    chk("rst/err", 32'(out_err), 32'd0);
    chk("rst/ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    run_op("enc0", 3'b100, 19'h00000, 19'h00802, 1'b0, 3, 0, 1'b0, '0);
    run_op("dec0", 3'b010, 19'h00802, 19'h00000, 1'b0, 3, 0, 1'b0, '0);

    r = DW'($urandom);
    c = enc_m(r, tb_key);
    run_op("rt_enc", 3'b100, r, c, 1'b0, 3, 0, 1'b0, '0);
    run_op("rt_dec", 3'b010, c, r, 1'b0, 3, 0, 1'b0, '0);

    // Key write on the accept edge: op must still see the old key.
    run_op("oldkey", 3'b100, 19'h00000, 19'h00802, 1'b0, 3, 0, 1'b1, 19'h5A5A5);
    run_op("newkey", 3'b100, 19'h00000, enc_m(19'h00000, 19'h5A5A5), 1'b0, 3, 0, 1'b0, '0);
    r = DW'($urandom);
    c = enc_m(r, tb_key);
    run_op("rt2_enc", 3'b100, r, c, 1'b0, 3, 0, 1'b0, '0);
    run_op("rt2_dec", 3'b010, c, r, 1'b0, 3, 0, 1'b0, '0);

    run_op("fft_a", 3'b001, 19'h00503, 19'h00802, 1'b0, 1, 0, 1'b0, '0);
`ifdef FED_SFU_SATURATE_EN
    run_op("fft_ovf", 3'b001, 19'h07F01, 19'h07F7E, 1'b0, 1, 0, 1'b0, '0);
    run_op("fft_neg", 3'b001, 19'h08001, 19'h08180, 1'b0, 1, 0, 1'b0, '0);
`else
    run_op("fft_ovf", 3'b001, 19'h07F01, 19'h0807E, 1'b0, 1, 0, 1'b0, '0);
    run_op("fft_neg", 3'b001, 19'h08001, 19'h0817F, 1'b0, 1, 0, 1'b0, '0);
`endif
    for (int i = 0; i < 3; i++) begin
      r = DW'($urandom);
      run_op("fft_rnd", 3'b001, r, fft_m(r), 1'b0, 1, 0, 1'b0, '0);
    end

    run_op("ill011", 3'b011, 19'h12345, 19'h00000, 1'b1, 1, 5, 1'b0, '0);
    run_op("ill000", 3'b000, 19'h7FFFF, 19'h00000, 1'b1, 1, 0, 1'b0, '0);
    run_op("ill111", 3'b111, 19'h00503, 19'h00000, 1'b1, 1, 0, 1'b0, '0);
    run_op("enc_bp", 3'b100, 19'h00000, enc_m(19'h00000, tb_key), 1'b0, 3, 5, 1'b0, '0);

    // Reset during the first RUN cycle of an ENC aborts it.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b100; in_data = 19'h12345;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tb_key = 19'h003FF;
    chk("mid_rst/valid", 32'(out_valid), 32'd0);
    chk("mid_rst/ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst/stale", 32'(out_valid), 32'd0);
    end
    run_op("post_rst", 3'b100, 19'h00000, 19'h00802, 1'b0, 3, 0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
